// File: rtl/hamming_link_ctrl.sv
// Sequences one 4-bit word through Hamming(7,4) encode/channel/syndrome/correct; optional HAMMING_ERR_INJECT_EN adds ERR_MASK.
// Latency: word accepted at edge N gives OUT_VALID after edge N+4; earliest transfer at N+5 (one word per 6 cycles).
// Backpressure: result is held stable in DONE until OUT_READY; IN_READY stays low until the result is consumed.
module hamming_link_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [3:0]       DIN,
`ifdef HAMMING_ERR_INJECT_EN
   input  logic [6:0]       ERR_MASK,
`endif
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [3:0]       DOUT,
   output logic [6:0]       CODE_OUT,
   output logic [2:0]       SYNDROME,
   output logic             ERR_FLAG,
   output logic             BUSY,
   output logic [CNT_W-1:0] WORD_CNT,
   output logic [CNT_W-1:0] ERR_CNT
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENCODE,
      S_CHANNEL,
      S_DECODE,
      S_CORRECT,
      S_DONE
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] data_q;
   logic [6:0] rx_q;
   logic [6:0] mask;
   logic [6:0] code_nxt;
   logic [2:0] syn_nxt;
   logic [6:0] rx_fix;
   logic [3:0] dout_nxt;
   logic       accept;
   logic       xfer;

`ifdef HAMMING_ERR_INJECT_EN
   assign mask = ERR_MASK;
`else
   assign mask = 7'd0;
`endif

   // Ready only in IDLE, and never while reset is being applied.
   assign IN_READY = (state == S_IDLE) && !CLR;
   assign accept   = IN_VALID && IN_READY;
   assign xfer     = OUT_VALID && OUT_READY;

   // Encoder: codeword index i holds position i+1, layout {d3,d2,d1,p4,d0,p2,p1}.
   always_comb begin
      code_nxt    = 7'd0;
      code_nxt[0] = data_q[0] ^ data_q[1] ^ data_q[3];
      code_nxt[1] = data_q[0] ^ data_q[2] ^ data_q[3];
      code_nxt[2] = data_q[0];
      code_nxt[3] = data_q[1] ^ data_q[2] ^ data_q[3];
      code_nxt[4] = data_q[1];
      code_nxt[5] = data_q[2];
      code_nxt[6] = data_q[3];
   end

   // Syndrome of the received word, packed as {s4,s2,s1}.
   always_comb begin
      syn_nxt    = 3'd0;
      syn_nxt[0] = rx_q[0] ^ rx_q[2] ^ rx_q[4] ^ rx_q[6];
      syn_nxt[1] = rx_q[1] ^ rx_q[2] ^ rx_q[5] ^ rx_q[6];
      syn_nxt[2] = rx_q[3] ^ rx_q[4] ^ rx_q[5] ^ rx_q[6];
   end

   // Single-bit correction: flip the bit whose position equals the registered syndrome.
   // Double errors alias to a wrong position; there is no detection of that case.
   always_comb begin
      rx_fix = rx_q;
      for (int i = 0; i < 7; i++) begin
         if (SYNDROME == 3'(i + 1)) begin
            rx_fix[i] = ~rx_q[i];
         end
      end
      dout_nxt = {rx_fix[6], rx_fix[5], rx_fix[4], rx_fix[2]};
   end

   // State register; BUSY is registered alongside so it tracks the state exactly.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state <= S_IDLE;
         BUSY  <= 1'b0;
      end else begin
         state <= state_nxt;
         BUSY  <= (state_nxt != S_IDLE);
      end
   end

   // Next-state logic: one pipeline step per clock, waiting only in IDLE and DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (accept) state_nxt = S_ENCODE;
         S_ENCODE:  state_nxt = S_CHANNEL;
         S_CHANNEL: state_nxt = S_DECODE;
         S_DECODE:  state_nxt = S_CORRECT;
         S_CORRECT: state_nxt = S_DONE;
         S_DONE:    if (xfer) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Datapath registers: each stage loads only in its own state, so outputs hold otherwise.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         data_q    <= 4'd0;
         rx_q      <= 7'd0;
         CODE_OUT  <= 7'd0;
         SYNDROME  <= 3'd0;
         DOUT      <= 4'd0;
         ERR_FLAG  <= 1'b0;
         OUT_VALID <= 1'b0;
      end else begin
         case (state)
            S_IDLE:    if (accept) data_q <= DIN;
            S_ENCODE:  CODE_OUT <= code_nxt;
            S_CHANNEL: rx_q <= CODE_OUT ^ mask;
            S_DECODE:  SYNDROME <= syn_nxt;
            S_CORRECT: begin
               DOUT      <= dout_nxt;
               ERR_FLAG  <= (SYNDROME != 3'd0);
               OUT_VALID <= 1'b1;
            end
            S_DONE:    if (xfer) OUT_VALID <= 1'b0;
            default:   ;
         endcase
      end
   end

   // Saturating statistics, updated only on a completed output handshake.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         WORD_CNT <= '0;
         ERR_CNT  <= '0;
      end else if (state == S_DONE && xfer) begin
         if (WORD_CNT != '1) WORD_CNT <= WORD_CNT + CNT_W'(1);
         if (ERR_FLAG && ERR_CNT != '1) ERR_CNT <= ERR_CNT + CNT_W'(1);
      end
   end

endmodule
